// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave controller and its helpers.
package microwave_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ENTRY = 3'd1,
        COOK  = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_e;

    typedef logic [3:0] bcd_t;

    localparam int unsigned KEY_W            = 10;
    localparam int unsigned TICK_DIV_DEFAULT = 50_000_000;

    // Encode a one-hot keypad vector into its BCD digit.
    function automatic bcd_t key_to_bcd(input logic [KEY_W-1:0] key);
        bcd_t d;
        d = '0;
        for (int i = 0; i < KEY_W; i++) begin
            if (key[i]) d = 4'(i);
        end
        return d;
    endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// Prescaler producing a one-cycle tick every DIV enabled cycles; holds its count
// while disabled and restarts from zero on i_clr.
module sec_tick_gen #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick_c
);

    localparam int unsigned CntW = (DIV > 2) ? $clog2(DIV) : 1;

    logic [CntW-1:0] r_cnt;
    logic            w_last;

    assign w_last   = (r_cnt == CntW'(DIV - 1));
    assign o_tick_c = i_en && w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_last ? '0 : r_cnt + CntW'(1);
        end
    end

endmodule

// File: rtl/microwave_controller.sv
// Microwave control FSM: keypad entry, cook/pause/done sequencing, second ticks.
// Build option DONE_AUTO_CLEAR_EN: leave DONE on its own after DONE_TICKS seconds.
module microwave_controller
    import microwave_pkg::*;
#(
    parameter int unsigned TICK_DIV   = TICK_DIV_DEFAULT,
    parameter int unsigned MAX_DIGITS = 3,
    parameter int unsigned DONE_TICKS = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [KEY_W-1:0] keypad,
    input  logic             start,
    input  logic             stop,
    input  logic             cancel,
    input  logic             door_closed,
    input  logic             timer_zero,
    output logic             timer_load,
    output bcd_t             timer_digit,
    output logic             timer_clear,
    output logic             timer_en,
    output logic             mag_on,
    output logic             done
);

`ifdef DONE_AUTO_CLEAR_EN
    localparam bit AutoClear = 1'b1;
`else
    localparam bit AutoClear = 1'b0;
`endif

    localparam int unsigned CntW     = $clog2(MAX_DIGITS + 1);
    localparam int unsigned DoneCntW = $clog2(DONE_TICKS + 1);

    logic [KEY_W-1:0]    r_key_q, r_key_d;
    logic                r_start_q, r_start_d;
    logic                r_stop_q, r_stop_d;
    logic                r_cancel_q, r_cancel_d;

    state_e              r_state, w_state_nxt;
    logic [CntW-1:0]     r_count, w_count_nxt;
    logic [DoneCntW-1:0] r_done_cnt, w_done_cnt_nxt;

    logic                w_load, w_clear, w_presc_clr;
    bcd_t                w_digit;
    logic                w_key_ev, w_start_ev, w_stop_ev, w_cancel_ev;
    logic                w_cook_exit, w_cook_run, w_done_ack, w_tick_en, w_tick;

    // Input edge-detect pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_q    <= '0;
            r_key_d    <= '0;
            r_start_q  <= 1'b0;
            r_start_d  <= 1'b0;
            r_stop_q   <= 1'b0;
            r_stop_d   <= 1'b0;
            r_cancel_q <= 1'b0;
            r_cancel_d <= 1'b0;
        end else begin
            r_key_q    <= keypad;
            r_key_d    <= r_key_q;
            r_start_q  <= start;
            r_start_d  <= r_start_q;
            r_stop_q   <= stop;
            r_stop_d   <= r_stop_q;
            r_cancel_q <= cancel;
            r_cancel_d <= r_cancel_q;
        end
    end

    // A key counts only when it is the sole key held and it has just risen.
    assign w_key_ev    = $onehot(r_key_q) && ((r_key_q & ~r_key_d) == r_key_q);
    assign w_start_ev  = r_start_q && !r_start_d;
    assign w_stop_ev   = r_stop_q && !r_stop_d;
    assign w_cancel_ev = r_cancel_q && !r_cancel_d;

    // Prescaler enable is derived from inputs only, so tick never feeds back into itself.
    assign w_cook_exit = w_cancel_ev || !door_closed || w_stop_ev || timer_zero;
    assign w_cook_run  = (r_state == COOK) && !w_cook_exit;
    assign w_done_ack  = w_cancel_ev || !door_closed || w_start_ev || w_key_ev;
    assign w_tick_en   = w_cook_run || (AutoClear && (r_state == DONE) && !w_done_ack);

    sec_tick_gen #(
        .DIV (TICK_DIV)
    ) u_sec_tick_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_presc_clr),
        .i_en     (w_tick_en),
        .o_tick_c (w_tick)
    );

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_count_nxt    = r_count;
        w_done_cnt_nxt = r_done_cnt;
        w_load         = 1'b0;
        w_digit        = '0;
        w_clear        = 1'b0;
        w_presc_clr    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_cancel_ev) begin
                    w_clear = 1'b1;
                end else if (w_key_ev) begin
                    w_load      = 1'b1;
                    w_digit     = key_to_bcd(r_key_q);
                    w_count_nxt = CntW'(1);
                    w_state_nxt = ENTRY;
                end
            end
            ENTRY: begin
                if (w_cancel_ev) begin
                    w_clear     = 1'b1;
                    w_count_nxt = '0;
                    w_state_nxt = IDLE;
                end else if (w_start_ev) begin
                    if (door_closed && !timer_zero) begin
                        w_presc_clr = 1'b1;
                        w_state_nxt = COOK;
                    end
                end else if (w_key_ev && (r_count < CntW'(MAX_DIGITS))) begin
                    w_load      = 1'b1;
                    w_digit     = key_to_bcd(r_key_q);
                    w_count_nxt = r_count + CntW'(1);
                end
            end
            COOK: begin
                if (w_cancel_ev) begin
                    w_clear     = 1'b1;
                    w_count_nxt = '0;
                    w_state_nxt = IDLE;
                end else if (!door_closed || w_stop_ev) begin
                    w_state_nxt = PAUSE;
                end else if (timer_zero) begin
                    w_presc_clr    = 1'b1;
                    w_done_cnt_nxt = '0;
                    w_state_nxt    = DONE;
                end
            end
            PAUSE: begin
                if (w_cancel_ev) begin
                    w_clear     = 1'b1;
                    w_count_nxt = '0;
                    w_state_nxt = IDLE;
                end else if (w_start_ev && door_closed) begin
                    w_state_nxt = COOK;
                end
            end
            DONE: begin
                if (w_done_ack) begin
                    w_clear     = w_cancel_ev;
                    w_count_nxt = '0;
                    w_state_nxt = IDLE;
                end else if (AutoClear && w_tick) begin
                    if (r_done_cnt == DoneCntW'(DONE_TICKS - 1)) begin
                        w_clear     = 1'b1;
                        w_count_nxt = '0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_done_cnt_nxt = r_done_cnt + DoneCntW'(1);
                    end
                end
            end
            default: begin
                w_count_nxt = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_done_cnt  <= '0;
            timer_load  <= 1'b0;
            timer_digit <= '0;
            timer_clear <= 1'b0;
            timer_en    <= 1'b0;
            mag_on      <= 1'b0;
            done        <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_count     <= w_count_nxt;
            r_done_cnt  <= w_done_cnt_nxt;
            timer_load  <= w_load;
            timer_digit <= w_digit;
            timer_clear <= w_clear;
            timer_en    <= w_cook_run && w_tick;
            mag_on      <= (w_state_nxt == COOK);
            done        <= (w_state_nxt == DONE);
        end
    end

endmodule

// File: tb/tb_microwave_controller.sv
// Directed bench for microwave_controller with TICK_DIV=4, MAX_DIGITS=3, DONE_TICKS=3.
module tb_microwave_controller;
    import microwave_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] keypad;
    logic       start, stop, cancel, door_closed, timer_zero;
    logic       timer_load, timer_clear, timer_en, mag_on, done;
    bcd_t       timer_digit;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    microwave_controller #(
        .TICK_DIV   (4),
        .MAX_DIGITS (3),
        .DONE_TICKS (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .keypad      (keypad),
        .start       (start),
        .stop        (stop),
        .cancel      (cancel),
        .door_closed (door_closed),
        .timer_zero  (timer_zero),
        .timer_load  (timer_load),
        .timer_digit (timer_digit),
        .timer_clear (timer_clear),
        .timer_en    (timer_en),
        .mag_on      (mag_on),
        .done        (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_key(input int d, input bit exp_load);
        keypad = 10'(1 << d);
        cycles(2);
        check("key_load", 32'(timer_load), 32'(exp_load));
        if (exp_load) check("key_digit", 32'(timer_digit), 32'(d));
        keypad = '0;
        cycles(1);
        check("key_pulse_end", 32'(timer_load), 0);
        cycles(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_done, n_clr, n_en;
        rst_n = 1'b0; keypad = '0; start = 0; stop = 0; cancel = 0;
        door_closed = 1'b1; timer_zero = 1'b0;
        cycles(3);
        check("reset_outputs", 32'({timer_load, timer_digit, timer_clear, timer_en, mag_on, done}), 0);
        check("reset_state", 32'(dut.r_state), 32'(IDLE));
        rst_n = 1'b1;
        cycles(2);

        // Digit entry, then one digit past the limit.
        press_key(1, 1'b1);
        check("entry_state", 32'(dut.r_state), 32'(ENTRY));
        press_key(3, 1'b1);
        press_key(0, 1'b1);
        check("entry_count", 32'(dut.r_count), 3);
        press_key(5, 1'b0);

        // Cook: mag_on 2 cycles after start, timer_en every 4 cycles.
        start = 1'b1;
        cycles(2);
        check("cook_mag_on", 32'(mag_on), 1);
        check("cook_en_first", 32'(timer_en), 0);
        start = 1'b0;
        cycles(3);
        check("cook_en_gap", 32'(timer_en), 0);
        cycles(1);
        check("cook_en_tick1", 32'(timer_en), 1);
        n_en = 0;
        for (int i = 0; i < 3; i++) begin
            cycles(1);
            n_en += int'(timer_en);
        end
        check("cook_en_between", 32'(n_en), 0);
        cycles(1);
        check("cook_en_tick2", 32'(timer_en), 1);
        timer_zero = 1'b1;
        cycles(1);
        check("zero_mag_off", 32'(mag_on), 0);
        check("zero_done_on", 32'(done), 1);
        check("zero_no_en", 32'(timer_en), 0);

        n_done = 0; n_clr = 0;
        for (int i = 0; i < 30; i++) begin
            cycles(1);
            n_done += int'(done);
            n_clr  += int'(timer_clear);
        end
`ifdef DONE_AUTO_CLEAR_EN
        check("auto_done_cycles", 32'(n_done), 11);
        check("auto_clear_pulses", 32'(n_clr), 1);
        check("auto_idle", 32'(dut.r_state), 32'(IDLE));
`else
        check("hold_done_cycles", 32'(n_done), 30);
        check("hold_no_clear", 32'(n_clr), 0);
        start = 1'b1;
        cycles(2);
        check("ack_done_off", 32'(done), 0);
        check("ack_idle", 32'(dut.r_state), 32'(IDLE));
        check("ack_no_clear", 32'(timer_clear), 0);
        start = 1'b0;
`endif
        timer_zero = 1'b0;
        cycles(2);

        // Door opens with the prescaler at 2; resume keeps the partial second.
        press_key(2, 1'b1);
        start = 1'b1;
        cycles(2);
        check("resume_setup_mag", 32'(mag_on), 1);
        start = 1'b0;
        cycles(2);
        door_closed = 1'b0;
        cycles(1);
        check("door_open_mag_off", 32'(mag_on), 0);
        check("door_open_state", 32'(dut.r_state), 32'(PAUSE));
        n_en = 0;
        for (int i = 0; i < 8; i++) begin
            cycles(1);
            n_en += int'(timer_en);
        end
        check("pause_no_en", 32'(n_en), 0);
        door_closed = 1'b1;
        start = 1'b1;
        cycles(2);
        check("resume_mag_on", 32'(mag_on), 1);
        start = 1'b0;
        cycles(1);
        check("resume_en_early", 32'(timer_en), 0);
        cycles(1);
        check("resume_en_tick", 32'(timer_en), 1);

        // Stop button pauses; cancel beats start in the same cycle.
        stop = 1'b1;
        cycles(2);
        check("stop_mag_off", 32'(mag_on), 0);
        stop = 1'b0;
        cycles(2);
        cancel = 1'b1; start = 1'b1;
        cycles(2);
        check("cancel_clear", 32'(timer_clear), 1);
        check("cancel_idle", 32'(dut.r_state), 32'(IDLE));
        check("cancel_mag", 32'(mag_on), 0);
        cycles(1);
        check("cancel_clear_end", 32'(timer_clear), 0);
        check("cancel_mag_hold", 32'(mag_on), 0);
        cancel = 1'b0; start = 1'b0;
        cycles(2);

        // Start with door open is ignored in ENTRY; multi-key is ignored.
        press_key(4, 1'b1);
        door_closed = 1'b0;
        start = 1'b1;
        cycles(3);
        check("open_start_mag", 32'(mag_on), 0);
        check("open_start_state", 32'(dut.r_state), 32'(ENTRY));
        start = 1'b0;
        door_closed = 1'b1;
        cycles(2);
        keypad = 10'b00_0000_1010;
        cycles(2);
        check("multikey_no_load", 32'(timer_load), 0);
        keypad = '0;
        cycles(2);
        check("multikey_count", 32'(dut.r_count), 1);
        press_key(7, 1'b1);
        cancel = 1'b1;
        cycles(2);
        check("entry_cancel_clear", 32'(timer_clear), 1);
        check("entry_cancel_count", 32'(dut.r_count), 0);
        cancel = 1'b0;
        cycles(2);

        // Reset during cook drops the magnetron at once.
        press_key(9, 1'b1);
        start = 1'b1;
        cycles(2);
        check("rst_setup_mag", 32'(mag_on), 1);
        start = 1'b0;
        cycles(1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_cook_mag", 32'(mag_on), 0);
        check("rst_mid_cook_state", 32'(dut.r_state), 32'(IDLE));
        cycles(2);
        rst_n = 1'b1;
        cycles(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
